data_ram_resp: RTL and testbench
================================

// Module: data_ram_resp
// PURPOSE
//   Responder for the core's data-memory port: receives ce/we/sel/addr/wdata from the MEM stage and returns rdata.
//   Writes are posted into a one-entry write buffer and retired into the word array on the next clock edge.
//   Reads are combinational; a read that hits the pending buffered word is merged per byte lane (store-to-load forwarding).
//   Sits outside the core, next to the instruction ROM, in the SoC top.
// PARAMETERS
//   ADDR_WIDTH  10  word-address bits; array depth = 2**ADDR_WIDTH 32-bit words
// PORTS
//   clk     in   1   system clock; all state updates on rising edge
//   rst     in   1   reset, asynchronous, active-low
//   ce_i    in   1   access enable from MEM stage
//   we_i    in   1   1 = write, 0 = read (valid only when ce_i=1)
//   sel_i   in   4   byte-lane select; sel_i[3] = data[31:24] ... sel_i[0] = data[7:0]
//   addr_i  in   32  byte address
//   data_i  in   32  write data (already lane-aligned by MEM stage)
//   data_o  out  32  read data
//   rd_cnt_o in/out  -- see CONFIGURATION
// BEHAVIOUR
//   Indexing: idx = addr_i[ADDR_WIDTH+1:2]; addr_i[1:0] and bits above ADDR_WIDTH+1 are ignored (aliasing wraps).
//   Write buffer state: pw_valid, pw_idx, pw_sel[3:0], pw_data[31:0].
//   Each rising edge, in this order of effect:
//     1. if pw_valid: array[pw_idx] lanes where pw_sel=1 <- pw_data lanes; other lanes unchanged.
//     2. if ce_i && we_i: load buffer {1, idx, sel_i, data_i}; else pw_valid <- 0.
//   Posted-write latency: a write is visible in the array exactly 1 edge after acceptance; visible on data_o the
//     cycle after acceptance (via forwarding).
//   Back-to-back writes: a new write is loaded while the previous one retires on the same edge; no stall, no loss.
//   Back-to-back writes to the same idx: the older retires first, the newer stays buffered; forwarding shows newest lanes.
//   sel_i=0 write: accepted, retires with no lane change.
//   Read (combinational): if ce_i && !we_i: data_o = array[idx], with lanes where pw_sel=1 replaced by pw_data when
//     pw_valid && pw_idx==idx. sel_i is ignored on reads (full word returned; the core extracts bytes).
//   data_o = 32'h0 when ce_i=0 or we_i=1.
//   Buffer drains even when ce_i=0.
//   Reset (rst=0, async): pw_valid <- 0, pw_idx/pw_sel/pw_data <- 0, counters <- 0; data_o follows the combinational
//     rule. The array is not reset; its contents are undefined until written.
//   Reset asserted with a buffered write pending: the write is discarded (never reaches the array).
//   Reset deassertion: writes are accepted on the first rising edge with rst=1.
// CONFIGURATION
//   Macro DATA_RAM_ACCESS_CNT_EN:
//     Defined: adds rd_cnt_o and wr_cnt_o, both out, 32-bit.
//       rd_cnt_o increments on each edge with ce_i && !we_i.
//       wr_cnt_o increments on each edge with ce_i && we_i.
//       Both wrap 32'hFFFF_FFFF -> 0 and are reset to 0.
//     Undefined: neither port nor counter exists; all other behaviour is identical.
// STRUCTURE
//   Shared package/defines file dram_pkg: RamWordBus [31:0], ByteSelBus [3:0], ByteAddrBus [31:0],
//     WriteEnable/ReadEnable, ChipEnable/ChipDisable, ZeroWord constant.
//   One sub-module, dram_array: 2**ADDR_WIDTH x 32 storage.
//     Write port: clocked, byte-lane mask, no reset.
//     Read port: asynchronous.
//   data_ram_resp holds the write buffer, forwarding merge, output gating and optional counters.
// TESTING
//   Write then read:
//     write addr 0x10, sel 4'b1111, data 0xDEADBEEF; next cycle read 0x10 -> data_o 0xDEADBEEF (forwarded);
//     a cycle later -> 0xDEADBEEF (from array).
//   Byte merge:
//     array[4] = 0x11223344; write sel 4'b0010, data 0x0000AA00; read addr 0x12 next cycle -> 0x1122AA44.
//   Same-address back-to-back:
//     write 0x20 = 0xAAAAAAAA (sel 1111), then 0x20 sel 0001 data 0x000000BB; read -> 0xAAAAAABB.
//   Reset mid-write:
//     accept a write to 0x30 (array previously 0x55555555); assert rst before the next edge; after release,
//     read 0x30 -> 0x55555555.
//   Idle/alias:
//     ce_i=0 -> data_o 0x0.
//     ADDR_WIDTH=10: a write to 0x1000 is read back at 0x0000.
//   DATA_RAM_ACCESS_CNT_EN:
//     3 reads + 2 writes -> rd_cnt_o = 3, wr_cnt_o = 2.
//     Preload rd_cnt to 0xFFFFFFFF via force, one read -> rd_cnt_o = 0.

Source files
------------

// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dram_pkg
// Description : Shared types and constants for the data-memory responder.
//               Word, byte-select and byte-address bus types, enable
//               encodings, the all-zero word and a byte-lane mask helper.
// Revision    : 1.0  initial release
// ============================================================================
package dram_pkg;

  typedef logic [31:0] ram_word_bus_t;
  typedef logic [3:0]  byte_sel_bus_t;
  typedef logic [31:0] byte_addr_bus_t;

  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b0;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam ram_word_bus_t ZERO_WORD = 32'h0000_0000;

  // Expand a 4-bit lane select into a 32-bit bit mask (lane n -> bits 8n+7:8n).
  function automatic ram_word_bus_t lane_mask(input byte_sel_bus_t sel);
    ram_word_bus_t m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram_resp_if.sv
`default_nettype none
// ============================================================================
// Interface   : data_ram_resp_if
// Description : MEM-stage data port bundle.
//   ce_i    access enable
//   we_i    1 = write, 0 = read
//   sel_i   byte-lane select
//   addr_i  byte address
//   data_i  lane-aligned write data
//   data_o  read data
//   master modport: the MEM stage; slave modport: the responder.
// Revision    : 1.0  initial release
// ============================================================================
interface data_ram_resp_if;
  import dram_pkg::*;

  logic           ce_i;
  logic           we_i;
  byte_sel_bus_t  sel_i;
  byte_addr_bus_t addr_i;
  ram_word_bus_t  data_i;
  ram_word_bus_t  data_o;

  modport master (
    output ce_i, we_i, sel_i, addr_i, data_i,
    input  data_o
  );

  modport slave (
    input  ce_i, we_i, sel_i, addr_i, data_i,
    output data_o
  );

endinterface
`default_nettype wire

// File: rtl/dram_array.sv
`default_nettype none
// ============================================================================
// Module      : dram_array
// Description : 2**ADDR_WIDTH x 32-bit word storage, no reset.
//   clk      write clock
//   we_i     write enable
//   widx_i   write word index
//   sel_i    byte-lane write mask
//   wdata_i  write data
//   ridx_i   read word index (asynchronous read)
//   rdata_o  read data
// Revision    : 1.0  initial release
// ============================================================================
module dram_array
  import dram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] widx_i,
  input  byte_sel_bus_t         sel_i,
  input  ram_word_bus_t         wdata_i,
  input  logic [ADDR_WIDTH-1:0] ridx_i,
  output ram_word_bus_t         rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  ram_word_bus_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_i[b]) begin
          mem[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem[ridx_i];

endmodule
`default_nettype wire

// File: rtl/data_ram_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_resp
// Description : Data-memory responder. Writes are posted into a one-entry
//               buffer and retired into dram_array on the following edge;
//               reads are combinational and merge the pending buffered word
//               per byte lane when the index matches.
//   clk       system clock
//   rst       asynchronous active-low reset
//   bus       data_ram_resp_if.slave (ce/we/sel/addr/data_i in, data_o out)
//   rd_cnt_o  read-access counter  (only with DATA_RAM_ACCESS_CNT_EN)
//   wr_cnt_o  write-access counter (only with DATA_RAM_ACCESS_CNT_EN)
// Optional macro: DATA_RAM_ACCESS_CNT_EN adds the access counters.
// Revision    : 1.0  initial release
// ============================================================================
module data_ram_resp
  import dram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  data_ram_resp_if.slave         bus
`ifdef DATA_RAM_ACCESS_CNT_EN
  ,
  output logic [31:0]            rd_cnt_o,
  output logic [31:0]            wr_cnt_o
`endif
);

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_rd;
  logic                  w_wr;

  logic                  pw_valid_q, pw_valid_d;
  logic [ADDR_WIDTH-1:0] pw_idx_q,   pw_idx_d;
  byte_sel_bus_t         pw_sel_q,   pw_sel_d;
  ram_word_bus_t         pw_data_q,  pw_data_d;

  ram_word_bus_t         w_arr_rdata;
  ram_word_bus_t         w_fwd_mask;
  ram_word_bus_t         w_merged;

  // Byte offset and bits above the array depth do not select a word;
  // addresses alias modulo the array size.
  logic                  w_unused_addr;

  assign w_idx         = bus.addr_i[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^{bus.addr_i[31:ADDR_WIDTH+2], bus.addr_i[1:0]};
  assign w_rd          = (bus.ce_i == CHIP_ENABLE) && (bus.we_i == READ_ENABLE);
  assign w_wr          = (bus.ce_i == CHIP_ENABLE) && (bus.we_i == WRITE_ENABLE);

  // Write buffer: reloaded on every accepted write, otherwise it empties.
  // The pending entry retires into the array on the same edge, so a new
  // write never has to wait.
  always_comb begin
    pw_valid_d = 1'b0;
    pw_idx_d   = pw_idx_q;
    pw_sel_d   = pw_sel_q;
    pw_data_d  = pw_data_q;
    if (w_wr) begin
      pw_valid_d = 1'b1;
      pw_idx_d   = w_idx;
      pw_sel_d   = bus.sel_i;
      pw_data_d  = bus.data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pw_valid_q <= 1'b0;
      pw_idx_q   <= '0;
      pw_sel_q   <= '0;
      pw_data_q  <= ZERO_WORD;
    end else begin
      pw_valid_q <= pw_valid_d;
      pw_idx_q   <= pw_idx_d;
      pw_sel_q   <= pw_sel_d;
      pw_data_q  <= pw_data_d;
    end
  end

  // pw_valid_q is cleared asynchronously, so a write pending at reset never
  // reaches the array.
  dram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .we_i    (pw_valid_q),
    .widx_i  (pw_idx_q),
    .sel_i   (pw_sel_q),
    .wdata_i (pw_data_q),
    .ridx_i  (w_idx),
    .rdata_o (w_arr_rdata)
  );

  // Store-to-load forwarding: only the lanes the pending write touches are
  // taken from the buffer; the rest come from the array.
  assign w_fwd_mask = (pw_valid_q && (pw_idx_q == w_idx)) ? lane_mask(pw_sel_q) : ZERO_WORD;
  assign w_merged   = (w_arr_rdata & ~w_fwd_mask) | (pw_data_q & w_fwd_mask);
  assign bus.data_o = w_rd ? w_merged : ZERO_WORD;

`ifdef DATA_RAM_ACCESS_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Free-running counters; natural 32-bit wrap.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (w_rd) rd_cnt_d = rd_cnt_q + 32'd1;
    if (w_wr) wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_ram_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_resp
// Description : Self-checking bench for data_ram_resp. A memory model that
//               makes every accepted write visible immediately (with an undo
//               record for a write cancelled by reset) predicts data_o; the
//               predictions are queued and a monitor compares them against
//               the DUT on the falling edge. Unwritten lanes are masked.
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_ram_resp;
  import dram_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_ram_resp_if bus ();

`ifdef DATA_RAM_ACCESS_CNT_EN
  logic [31:0] rd_cnt, wr_cnt;
`endif

  data_ram_resp #(
    .ADDR_WIDTH (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef DATA_RAM_ACCESS_CNT_EN
    ,
    .rd_cnt_o (rd_cnt),
    .wr_cnt_o (wr_cnt)
`endif
  );

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: word contents plus which byte lanes are known.
  logic [31:0] m_mem   [DEPTH];
  logic [3:0]  m_known [DEPTH];
  bit          u_valid;
  int          u_idx;
  logic [31:0] u_word;
  logic [3:0]  u_known;
  logic [31:0] exp_rd = 0;
  logic [31:0] exp_wr = 0;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = s[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Monitor: one prediction per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.mask != 0) begin
        n_chk++;
        if ((bus.data_o & e.mask) === (e.exp & e.mask)) n_pass++;
        else $display("FAIL data_o tag%0d: got %h want %h (lane mask %h)",
                      e.tag, bus.data_o, e.exp, e.mask);
      end
    end
  end

  // Drive one cycle at posedge+1, predict data_o, then advance the model.
  task automatic drive(input bit ce, input bit we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] data, input int tag);
    exp_t e;
    int   i;
    bus.ce_i   = ce;
    bus.we_i   = we;
    bus.sel_i  = sel;
    bus.addr_i = addr;
    bus.data_i = data;
    e.tag = tag;
    if (ce && !we) begin
      i      = idx_of(addr);
      e.exp  = m_mem[i];
      e.mask = lanes(m_known[i]);
    end else begin
      e.exp  = 32'h0;
      e.mask = 32'hFFFF_FFFF;
    end
    sb.push_back(e);
    @(posedge clk);
    if (rst) begin
      u_valid = 0;
      if (ce && we) begin
        i       = idx_of(addr);
        u_valid = 1;
        u_idx   = i;
        u_word  = m_mem[i];
        u_known = m_known[i];
        for (int b = 0; b < 4; b++)
          if (sel[b]) m_mem[i][b*8 +: 8] = data[b*8 +: 8];
        m_known[i] = m_known[i] | sel;
        exp_wr++;
      end
      if (ce && !we) exp_rd++;
    end
    #1;
  endtask

  task automatic idle(input int tag);
    drive(CHIP_DISABLE, 1'b0, 4'h0, 32'h0, 32'h0, tag);
  endtask

  task automatic rd(input logic [31:0] a, input int tag);
    drive(1'b1, 1'b0, 4'hF, a, 32'h0, tag);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    drive(1'b1, 1'b1, s, a, d, 0);
  endtask

  // Assert reset before the next edge; the most recently accepted write
  // (still posted) is lost, so the model undoes it.
  task automatic do_reset();
    rst = 1'b0;
    if (u_valid) begin
      m_mem[u_idx]   = u_word;
      m_known[u_idx] = u_known;
    end
    u_valid = 0;
    exp_rd  = 0;
    exp_wr  = 0;
    idle(50);
    idle(51);
    rst = 1'b1;
  endtask

`ifdef DATA_RAM_ACCESS_CNT_EN
  task automatic check_cnt(input string nm);
    n_chk++;
    if (rd_cnt === exp_rd && wr_cnt === exp_wr) n_pass++;
    else $display("FAIL cnt_%s: got rd=%h wr=%h want rd=%h wr=%h",
                  nm, rd_cnt, wr_cnt, exp_rd, exp_wr);
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = 32'h0;
      m_known[i] = 4'h0;
    end
    u_valid    = 0;
    rst        = 1'b0;
    bus.ce_i   = 1'b0;
    bus.we_i   = 1'b0;
    bus.sel_i  = 4'h0;
    bus.addr_i = 32'h0;
    bus.data_i = 32'h0;
    @(posedge clk);
    #1;
    idle(1);                                   // reset state: data_o = 0
`ifdef DATA_RAM_ACCESS_CNT_EN
    check_cnt("reset");
`endif
    rst = 1'b1;

    // Write then read (forwarded, then from array).
    wr(32'h10, 4'hF, 32'hDEAD_BEEF);
    rd(32'h10, 2);
    rd(32'h10, 3);

    // Byte merge into a resident word.
    wr(32'h10, 4'hF, 32'h1122_3344);
    idle(4);
    wr(32'h12, 4'b0010, 32'h0000_AA00);
    rd(32'h12, 5);
    rd(32'h12, 6);

    // Same-address back-to-back writes.
    wr(32'h20, 4'hF, 32'hAAAA_AAAA);
    wr(32'h20, 4'b0001, 32'h0000_00BB);
    rd(32'h20, 7);
    idle(8);
    rd(32'h20, 9);

    // Reset with a write still posted.
    wr(32'h30, 4'hF, 32'h5555_5555);
    idle(10);
    wr(32'h30, 4'hF, 32'h1234_5678);
    do_reset();
    rd(32'h30, 11);
    // First edge after release accepts a write.
    wr(32'h34, 4'hF, 32'h0BAD_F00D);
    rd(32'h34, 12);

    // sel=0 write changes nothing.
    wr(32'h30, 4'h0, 32'hFFFF_FFFF);
    rd(32'h30, 13);
    rd(32'h30, 14);

    // Alias: 0x1000 maps onto word 0.
    wr(32'h1000, 4'hF, 32'hCAFE_F00D);
    rd(32'h0000, 15);
    idle(16);
    rd(32'h0000, 17);

    // Randomised traffic over a small window with aliased high bits.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 60) == 0) do_reset();
      else drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 4'($urandom),
                 a, $urandom, 100);
    end

`ifdef DATA_RAM_ACCESS_CNT_EN
    do_reset();
    check_cnt("after_reset");
    rd(32'h0, 200);
    wr(32'h4, 4'hF, 32'h1);
    rd(32'h4, 201);
    wr(32'h8, 4'hF, 32'h2);
    rd(32'h8, 202);
    check_cnt("three_two");
    force dut.rd_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.rd_cnt_q;
    exp_rd = 32'hFFFF_FFFF;
    rd(32'h4, 203);
    check_cnt("wrap");
`endif

    idle(0);
    repeat (2) @(negedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d queued want 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
